sgdmac_apb_master: RTL and testbench
====================================

Name: sgdmac_apb_master

Overview:
APB requester (initiator) for the SGDMAC subsystem. It converts single-beat commands on a valid/ready command port into APB SETUP/ACCESS transfers, and returns read data and error status on a valid/ready response port. It drives the DMAC configuration slave (VERSION 0x000, START 0x100, CONTROL 0x104, STATUS 0x108) from a test sequencer or a host-side bridge. It handles wait states, slave errors and a bounded-wait timeout.

Parameters:
ADDR_W, 12, APB address width
DATA_W, 32, APB data width
TIMEOUT, 255, maximum ACCESS cycles with pready_i low before abort; 0 disables the timeout

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid and ready are both high
cmd_write_i  input  1  1 = write, 0 = read
cmd_addr_i  input  ADDR_W  target address
cmd_wdata_i  input  DATA_W  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid and ready are both high
rsp_rdata_o  output  DATA_W  read data; 0 for writes and for aborted transfers
rsp_slverr_o  output  1  pslverr_i sampled at completion, or 1 on timeout
rsp_timeout_o  output  1  transfer aborted by timeout
psel_o  output  1  APB select
penable_o  output  1  APB enable
paddr_o  output  ADDR_W  APB address
pwrite_o  output  1  APB direction
pwdata_o  output  DATA_W  APB write data
pready_i  input  1  APB ready
prdata_i  input  DATA_W  APB read data
pslverr_i  input  1  APB slave error

Behaviour:
- Reset: asserting rst clears every output and register to 0 immediately (asynchronous) and forces state IDLE. Reset mid-transfer drops psel_o/penable_o at once; no response is produced for the lost command.
- All APB and response outputs come directly from flops; there are no combinational paths from inputs to outputs except cmd_ready_o, which decodes state only.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, latch write/addr/wdata into paddr_o/pwrite_o/pwdata_o and go to SETUP.
  - cmd_ready_o = 0 in every other state.
- SETUP (exactly 1 cycle): psel_o = 1, penable_o = 0; then go to ACCESS.
- ACCESS: psel_o = 1, penable_o = 1.
  - Each cycle with pready_i = 0 increments the 8-bit wait counter (counter cleared on SETUP entry).
  - When pready_i = 1: capture rsp_rdata_o = pwrite_o ? 0 : prdata_i and rsp_slverr_o = pslverr_i; set rsp_timeout_o = 0; go to RESP.
  - pslverr_i and prdata_i are ignored when pready_i = 0.
  - If TIMEOUT != 0 and the counter equals TIMEOUT while pready_i = 0: go to RESP with rsp_slverr_o = 1, rsp_timeout_o = 1, rsp_rdata_o = 0.
  - pready_i takes priority over timeout in the same cycle.
- RESP:
  - psel_o = 0, penable_o = 0, rsp_valid_o = 1.
  - rsp_* are held stable until rsp_ready_i = 1, then go to IDLE (rsp_valid_o = 0 the next cycle).
  - The next command can be accepted in the cycle after the response handshake; there is no overlap of commands.
- paddr_o, pwrite_o and pwdata_o are held constant from SETUP through ACCESS and keep their last values in RESP and IDLE.
- Latency (zero-wait slave): command accepted at cycle 0; SETUP at cycle 1; ACCESS at cycle 2 with pready_i = 1; rsp_valid_o at cycle 3. Each wait state adds one cycle.
- Throughput: with rsp_ready_i held high, a new command every 4 cycles.
- The wait counter saturates at 255 (no wrap-around). The effective TIMEOUT is limited to 1..255.

Test Plan:
1. Write with zero-wait slave: write cmd, addr 0x100, wdata 0xA5A5_0001; pready_i = 1 -> psel_o high in cycles 1-2, penable_o high in cycle 2 only; rsp_valid_o in cycle 3 with rdata 0, slverr 0.
2. Read with 3 wait states: read cmd, addr 0x000; pready_i low for 3 ACCESS cycles, then high with prdata_i = 0x0101_2024 -> penable_o high for 4 cycles, paddr_o stable; rsp_rdata_o = 0x0101_2024 at cycle 6.
3. Slave error: read cmd, addr 0x10C; pslverr_i = 1 with pready_i = 1 -> rsp_slverr_o = 1, rsp_timeout_o = 0; pslverr_i = 1 during wait cycles alone has no effect.
4. Timeout: TIMEOUT = 4; pready_i held low -> after 4 wait cycles psel_o drops; rsp_slverr_o = 1, rsp_timeout_o = 1, rdata 0. Repeat with pready_i rising in the same cycle as the limit -> normal completion.
5. Backpressure and back-to-back: two queued commands; rsp_ready_i low for 5 cycles -> rsp_* held stable, cmd_ready_o = 0 and no APB activity; the second command starts only after the first response handshake.
6. Reset mid-ACCESS: assert rst asynchronously between clock edges during ACCESS -> psel_o, penable_o and rsp_valid_o go to 0 before the next edge; after release, cmd_ready_o = 1 and a fresh read completes normally.

Source files
------------

// File: rtl/sgdmac_apb_master.sv
// APB requester for the SGDMAC configuration slave.
// Turns single-beat valid/ready commands into APB SETUP/ACCESS transfers and
// returns read data plus error/timeout status on a valid/ready response port.
module sgdmac_apb_master #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // command port
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  // response port
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_slverr_o,
  output logic              rsp_timeout_o,
  // APB requester
  output logic              psel_o,
  output logic              penable_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic              pwrite_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic              pready_i,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pslverr_i
);

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  // Limit clamped into the counter range; a zero TIMEOUT disables the abort.
  localparam logic [CNT_W-1:0] TO_LIM =
    (TIMEOUT > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(TIMEOUT);
  localparam bit TO_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // Ready is a pure state decode so commands are only taken when idle.
  assign cmd_ready_o = (state == IDLE);

  // Transfer sequencer: state, wait counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      psel_o        <= 1'b0;
      penable_o     <= 1'b0;
      paddr_o       <= '0;
      pwrite_o      <= 1'b0;
      pwdata_o      <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_slverr_o  <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            paddr_o   <= cmd_addr_i;
            pwrite_o  <= cmd_write_i;
            pwdata_o  <= cmd_wdata_i;
            psel_o    <= 1'b1;
            penable_o <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (pready_i) begin
            // Completion wins over a timeout reached in the same cycle.
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
            rsp_slverr_o  <= pslverr_i;
            rsp_timeout_o <= 1'b0;
            state         <= RESP;
          end else if (TO_EN && (wait_cnt == TO_LIM)) begin
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_rdata_o   <= '0;
            rsp_slverr_o  <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state         <= RESP;
          end else if (wait_cnt != CNT_W'(CNT_MAX)) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sgdmac_apb_master.sv
// Self-checking bench for sgdmac_apb_master: directed scenarios plus a
// randomized run checked against a transaction-level timeline model.
module tb_sgdmac_apb_master;

  localparam int unsigned ADDR_W  = 12;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int          NEVER   = 1000;

  logic              clk;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              psel, penable, pwrite, pready, pslverr;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata, prdata;

  sgdmac_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_slverr_o(rsp_slverr), .rsp_timeout_o(rsp_timeout),
    .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  int n_chk  = 0;
  int n_fail = 0;

  // Observations gathered by one transfer.
  logic              o_ready, o_slverr, o_timeout, o_after;
  logic [DATA_W-1:0] o_rdata;
  int                o_lat, o_psel, o_pen, o_setup, o_acc, o_hs;
  bit                o_bus_ok, o_stable, o_quiet, o_hang;

  // Drives one command and plays an APB slave that raises pready after
  // 'waits' ACCESS cycles; returns what it saw in the o_* variables.
  task automatic do_xfer(input logic wr, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int waits,
                         input logic [DATA_W-1:0] rdata, input logic serr,
                         input int hold, input bit keep_valid,
                         input logic [ADDR_W-1:0] nxt_addr);
    int cyc, hcnt;
    bit seen, done;
    cyc = 0; hcnt = 0; seen = 0; done = 0;
    o_ready = cmd_ready; o_lat = -1; o_psel = 0; o_pen = 0; o_setup = 0;
    o_acc = -1; o_hs = -1; o_bus_ok = 1; o_stable = 1; o_quiet = 1; o_hang = 0;
    o_after = 1'b1; o_rdata = '0; o_slverr = 1'b0; o_timeout = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    pready = 1'b0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        o_acc = cyc_g;
        if (keep_valid) begin
          cmd_addr  = nxt_addr;
          cmd_wdata = ~wdata;
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (seen && rsp_ready) begin
        o_hs      = cyc_g;
        o_after   = rsp_valid;
        rsp_ready = 1'b0;
        done      = 1;
      end else begin
        if (psel) begin
          o_psel++;
          if (penable) o_pen++; else o_setup++;
          if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) o_bus_ok = 0;
        end
        if (psel && penable) begin
          if (o_pen - 1 >= waits) begin
            pready = 1'b1; prdata = rdata; pslverr = serr;
          end else begin
            pready = 1'b0; prdata = $urandom; pslverr = 1'b1;
          end
        end else begin
          pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        end
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1; o_lat = cyc;
            o_rdata = rsp_rdata; o_slverr = rsp_slverr; o_timeout = rsp_timeout;
          end else if (rsp_rdata !== o_rdata || rsp_slverr !== o_slverr ||
                       rsp_timeout !== o_timeout) begin
            o_stable = 0;
          end
          if (psel || penable || cmd_ready) o_quiet = 0;
          if (hcnt == hold) rsp_ready = 1'b1; else hcnt++;
        end
        if (cyc > 2000) begin
          o_hang = 1; done = 1; rsp_ready = 1'b0;
        end
      end
    end
    cmd_valid = keep_valid;
    pready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({psel, penable, rsp_valid, pwrite, rsp_slverr, rsp_timeout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {psel, penable, rsp_valid, pwrite, rsp_slverr, rsp_timeout});
    end
    n_chk++;
    if (paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: paddr=%h pwdata=%h rdata=%h want 0", paddr, pwdata, rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait();
    do_xfer(1'b1, 12'h100, 32'hA5A5_0001, 0, 32'hDEAD_BEEF, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_lat !== 3 || o_setup !== 1 || o_pen !== 1) begin
      n_fail++;
      $display("FAIL wr_timing: lat=%0d setup=%0d pen=%0d want 3 1 1", o_lat, o_setup, o_pen);
    end
    n_chk++;
    if (o_rdata !== '0 || o_slverr !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp: rdata=%h slverr=%b to=%b want 0 0 0", o_rdata, o_slverr, o_timeout);
    end
    n_chk++;
    if (!o_bus_ok || o_ready !== 1'b1 || o_after !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_bus: bus_ok=%0d ready=%b valid_after=%b want 1 1 0", o_bus_ok, o_ready, o_after);
    end
  endtask

  task automatic test_read_waits();
    do_xfer(1'b0, 12'h000, 32'h0, 3, 32'h0101_2024, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_pen !== 4 || o_lat !== 6 || !o_bus_ok) begin
      n_fail++;
      $display("FAIL rd_wait_timing: pen=%0d lat=%0d bus_ok=%0d want 4 6 1", o_pen, o_lat, o_bus_ok);
    end
    n_chk++;
    if (o_rdata !== 32'h0101_2024 || o_slverr !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_wait_data: rdata=%h slverr=%b want 01012024 0", o_rdata, o_slverr);
    end
  endtask

  task automatic test_slverr();
    do_xfer(1'b0, 12'h10C, 32'h0, 2, 32'h1234_5678, 1'b1, 0, 0, '0);
    n_chk++;
    if (o_slverr !== 1'b1 || o_timeout !== 1'b0 || o_rdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL slverr_set: slverr=%b to=%b rdata=%h want 1 0 12345678", o_slverr, o_timeout, o_rdata);
    end
    // pslverr is driven high in every wait cycle; only the ready cycle counts.
    do_xfer(1'b0, 12'h10C, 32'h0, 2, 32'h0000_00AA, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_slverr !== 1'b0 || o_rdata !== 32'h0000_00AA) begin
      n_fail++;
      $display("FAIL slverr_wait_ignored: slverr=%b rdata=%h want 0 000000aa", o_slverr, o_rdata);
    end
  endtask

  task automatic test_timeout();
    do_xfer(1'b0, 12'h108, 32'h0, NEVER, 32'h5555_5555, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_pen !== int'(TIMEOUT) + 1 || o_lat !== 3 + int'(TIMEOUT) || o_hang) begin
      n_fail++;
      $display("FAIL to_timing: pen=%0d lat=%0d hang=%0d want %0d %0d 0",
               o_pen, o_lat, o_hang, TIMEOUT + 1, TIMEOUT + 3);
    end
    n_chk++;
    if (o_slverr !== 1'b1 || o_timeout !== 1'b1 || o_rdata !== '0) begin
      n_fail++;
      $display("FAIL to_rsp: slverr=%b to=%b rdata=%h want 1 1 0", o_slverr, o_timeout, o_rdata);
    end
    do_xfer(1'b0, 12'h108, 32'h0, int'(TIMEOUT), 32'h0BAD_F00D, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_timeout !== 1'b0 || o_slverr !== 1'b0 || o_rdata !== 32'h0BAD_F00D ||
        o_lat !== 3 + int'(TIMEOUT)) begin
      n_fail++;
      $display("FAIL to_edge_ready: to=%b slverr=%b rdata=%h lat=%0d want 0 0 0badf00d %0d",
               o_timeout, o_slverr, o_rdata, o_lat, TIMEOUT + 3);
    end
  endtask

  task automatic test_back_to_back();
    int hs, a0, a1, a2;
    do_xfer(1'b0, 12'h100, 32'h0, 1, 32'hCAFE_0001, 1'b0, 5, 1, 12'h104);
    hs = o_hs;
    n_chk++;
    if (!o_stable || !o_quiet || !o_bus_ok || o_psel !== 3) begin
      n_fail++;
      $display("FAIL bp_hold: stable=%0d quiet=%0d bus_ok=%0d psel=%0d want 1 1 1 3",
               o_stable, o_quiet, o_bus_ok, o_psel);
    end
    do_xfer(1'b1, 12'h104, 32'h0000_0003, 0, 32'h0, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_acc !== hs + 1 || o_ready !== 1'b1 || !o_bus_ok) begin
      n_fail++;
      $display("FAIL bp_second_start: acc=%0d ready=%b bus_ok=%0d want %0d 1 1",
               o_acc, o_ready, o_bus_ok, hs + 1);
    end
    do_xfer(1'b1, 12'h104, 32'h1, 0, 32'h0, 1'b0, 0, 0, '0); a0 = o_acc;
    do_xfer(1'b0, 12'h108, 32'h0, 0, 32'h7, 1'b0, 0, 0, '0); a1 = o_acc;
    do_xfer(1'b0, 12'h000, 32'h0, 0, 32'h9, 1'b0, 0, 0, '0); a2 = o_acc;
    n_chk++;
    if (a1 - a0 !== 4 || a2 - a1 !== 4) begin
      n_fail++;
      $display("FAIL throughput: gaps=%0d,%0d want 4,4", a1 - a0, a2 - a1);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h104; cmd_wdata = '0;
    pready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (psel !== 1'b1 || penable !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: psel=%b penable=%b want 1 1", psel, penable);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || paddr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_async: psel=%b penable=%b rsp_valid=%b paddr=%h want 0 0 0 0",
               psel, penable, rsp_valid, paddr);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || psel !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: ready=%b rsp_valid=%b psel=%b want 1 0 0", cmd_ready, rsp_valid, psel);
    end
    do_xfer(1'b0, 12'h000, 32'h0, 1, 32'h0101_2024, 1'b0, 0, 0, '0);
    n_chk++;
    if (o_rdata !== 32'h0101_2024 || o_lat !== 4 || o_slverr !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_fresh: rdata=%h lat=%0d slverr=%b want 01012024 4 0", o_rdata, o_lat, o_slverr);
    end
  endtask

  task automatic test_random();
    logic              wr, serr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata, rdata, e_rdata;
    int                waits, hold, e_lat, e_pen;
    bit                e_to;
    logic [ADDR_W-1:0] regs [4];
    regs[0] = 12'h000; regs[1] = 12'h100; regs[2] = 12'h104; regs[3] = 12'h108;
    for (int i = 0; i < 40; i++) begin
      wr    = 1'($urandom);
      addr  = ($urandom_range(0, 4) == 4) ? ADDR_W'($urandom) : regs[$urandom_range(0, 3)];
      wdata = $urandom;
      rdata = $urandom;
      serr  = ($urandom_range(0, 3) == 0);
      waits = $urandom_range(0, int'(TIMEOUT) + 2);
      hold  = $urandom_range(0, 3);
      // Reference: a transfer aborts once more than TIMEOUT wait cycles elapse.
      e_to    = (waits > int'(TIMEOUT));
      e_pen   = e_to ? int'(TIMEOUT) + 1 : waits + 1;
      e_lat   = 2 + e_pen;
      e_rdata = (e_to || wr) ? '0 : rdata;
      do_xfer(wr, addr, wdata, waits, rdata, serr, hold, 0, '0);
      n_chk++;
      if (o_rdata !== e_rdata || o_slverr !== (e_to ? 1'b1 : serr) || o_timeout !== e_to) begin
        n_fail++;
        $display("FAIL rand_rsp[%0d]: rdata=%h slverr=%b to=%b want %h %b %b",
                 i, o_rdata, o_slverr, o_timeout, e_rdata, e_to ? 1'b1 : serr, e_to);
      end
      n_chk++;
      if (o_lat !== e_lat || o_pen !== e_pen || o_setup !== 1) begin
        n_fail++;
        $display("FAIL rand_timing[%0d]: lat=%0d pen=%0d setup=%0d want %0d %0d 1",
                 i, o_lat, o_pen, o_setup, e_lat, e_pen);
      end
      n_chk++;
      if (!o_bus_ok || !o_stable || !o_quiet || o_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_proto[%0d]: bus_ok=%0d stable=%0d quiet=%0d ready=%b want 1 1 1 1",
                 i, o_bus_ok, o_stable, o_quiet, o_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
